// File: rtl/cprv_pkg.sv
// Shared opcodes, FSM state type and operand-usage decode for the CPRV hazard controller.
package cprv_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OP, OP_IMM, OP_32, OP_IMM_32, LOAD: writes_rd = 1'b1;
            default:                            writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        case (opc)
            OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE: uses_rs1 = 1'b1;
            default:                                   uses_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OP, OP_32, STORE: uses_rs2 = 1'b1;
            default:          uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cprv_scoreboard.sv
// Pending-write bitmap: one bit per architectural register, x0 never pending.
module cprv_scoreboard
(
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en_i,
    input  logic [4:0] set_addr_i,
    input  logic       clr_en_i,
    input  logic [4:0] clr_addr_i,
    input  logic       flush_i,
    input  logic [4:0] rd_addr_a_i,
    input  logic [4:0] rd_addr_b_i,
    output logic       pend_a_o,
    output logic       pend_b_o
);

    logic [31:0] r_pending;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_pending_nxt;

    // Next bitmap: flush wipes everything, otherwise a set beats a clear of the same bit.
    always_comb begin
        w_set_mask    = 32'd0;
        w_clr_mask    = 32'd0;
        w_pending_nxt = r_pending;
        if (set_en_i) begin
            w_set_mask = 32'd1 << set_addr_i;
        end else begin
            w_set_mask = 32'd0;
        end
        if (clr_en_i) begin
            w_clr_mask = 32'd1 << clr_addr_i;
        end else begin
            w_clr_mask = 32'd0;
        end
        if (flush_i) begin
            w_pending_nxt = 32'd0;
        end else begin
            w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Bitmap register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign pend_a_o = r_pending[rd_addr_a_i];
    assign pend_b_o = r_pending[rd_addr_b_i];

endmodule

// File: rtl/cprv_hazard_ctrl.sv
// RAW interlock, in-flight limiter and flush sequencer between IF and ID.
// Define CPRV_HAZARD_BYPASS_EN to let a same-cycle writeback satisfy a dependency.
module cprv_hazard_ctrl #(
    parameter int INSTR_WIDTH  = 32,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_id_i,
    input  logic [INSTR_WIDTH-1:0] instr_data_id_i,
    output logic                   ready_id_o,
    output logic                   valid_dec_o,
    input  logic                   ready_dec_i,
    input  logic                   wb_en_i,
    input  logic [4:0]             wb_addr_i,
    input  logic                   retire_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic [3:0]             inflight_o,
    output logic [1:0]             state_o
);
    import cprv_pkg::*;

    localparam logic [3:0] LP_MAX_INFLIGHT = 4'(MAX_INFLIGHT);

    hz_state_e  r_state;
    hz_state_e  w_state_nxt;
    logic [3:0] r_inflight;
    logic [3:0] w_inflight_nxt;

    logic [6:0] w_opc;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_pend_rs1;
    logic       w_pend_rs2;
    logic       w_byp_rs1;
    logic       w_byp_rs2;
    logic       w_hazard;
    logic       w_full;
    logic       w_run;
    logic       w_stall;
    logic       w_issue;
    logic       w_retire_dec;
    logic       w_unused;

    assign w_opc    = instr_data_id_i[6:0];
    assign w_rd     = instr_data_id_i[11:7];
    assign w_rs1    = instr_data_id_i[19:15];
    assign w_rs2    = instr_data_id_i[24:20];
    assign w_unused = ^{instr_data_id_i[INSTR_WIDTH-1:25], instr_data_id_i[14:12]};

    cprv_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (w_issue && writes_rd(w_opc)),
        .set_addr_i  (w_rd),
        .clr_en_i    (wb_en_i),
        .clr_addr_i  (wb_addr_i),
        .flush_i     (flush_i),
        .rd_addr_a_i (w_rs1),
        .rd_addr_b_i (w_rs2),
        .pend_a_o    (w_pend_rs1),
        .pend_b_o    (w_pend_rs2)
    );

`ifdef CPRV_HAZARD_BYPASS_EN
    assign w_byp_rs1 = wb_en_i && (wb_addr_i == w_rs1);
    assign w_byp_rs2 = wb_en_i && (wb_addr_i == w_rs2);
`else
    assign w_byp_rs1 = 1'b0;
    assign w_byp_rs2 = 1'b0;
`endif

    assign w_hazard = (uses_rs1(w_opc) && w_pend_rs1 && !w_byp_rs1) ||
                      (uses_rs2(w_opc) && w_pend_rs2 && !w_byp_rs2);
    assign w_full   = (r_inflight == LP_MAX_INFLIGHT);
    assign w_run    = (r_state == ST_RUN);
    assign w_stall  = w_run && valid_id_i && (w_hazard || w_full);
    assign w_issue  = valid_dec_o && ready_dec_i;
    // A retire with nothing outstanding is a stray pulse and must not wrap the counter.
    assign w_retire_dec = retire_i && (r_inflight != 4'd0);

    assign stall_o     = w_stall;
    assign valid_dec_o = valid_id_i && w_run && !w_stall;
    assign ready_id_o  = ready_dec_i && w_run && !w_stall;
    assign inflight_o  = r_inflight;
    assign state_o     = r_state;

    // Next state: flush overrides everything; STALL re-arms once the offered instruction is clear.
    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_FLUSH;
        end else begin
            case (r_state)
                ST_RUN:   w_state_nxt = w_stall ? ST_STALL : ST_RUN;
                ST_STALL: w_state_nxt = (valid_id_i && (w_hazard || w_full)) ? ST_STALL : ST_RUN;
                ST_FLUSH: w_state_nxt = (r_inflight == 4'd0) ? ST_RUN : ST_FLUSH;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    // Next in-flight count.
    always_comb begin
        w_inflight_nxt = r_inflight;
        case ({w_issue, w_retire_dec})
            2'b10:   w_inflight_nxt = r_inflight + 4'd1;
            2'b01:   w_inflight_nxt = r_inflight - 4'd1;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_inflight <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inflight_nxt;
        end
    end

endmodule
